// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// State encoding, bank/address geometry and the per-port request bundle.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  localparam int SRAM_AW  = 13;
  localparam int BANK_BIT = 15;

  typedef struct packed {
    logic        req;
    logic        lock;
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } port_req_t;

endpackage

// File: rtl/sram_bank_decode.sv
// Byte-lane enable steering onto bank 0 (SRAM0-3) or bank 1 (SRAM4-7).
// Purely combinational; no enables when there is no access.
module sram_bank_decode (
  input  logic       bank,
  input  logic [3:0] be,
  input  logic       en,
  output logic [3:0] bank0_sel,
  output logic [3:0] bank1_sel
);

  always_comb begin
    bank0_sel = '0;
    bank1_sel = '0;
    if (en) begin
      if (bank) bank1_sel = be;
      else      bank0_sel = be;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin SRAM arbiter with burst lock and 1-cycle read return.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic               hclk,
  input  logic               hrst_n,
  input  logic               p0_req,
  input  logic               p1_req,
  input  logic               p0_lock,
  input  logic               p1_lock,
  input  logic               p0_we,
  input  logic               p1_we,
  input  logic [15:0]        p0_addr,
  input  logic [15:0]        p1_addr,
  input  logic [3:0]         p0_be,
  input  logic [3:0]         p1_be,
  input  logic [31:0]        p0_wdata,
  input  logic [31:0]        p1_wdata,
  output logic               p0_gnt,
  output logic               p1_gnt,
  output logic               p0_rvalid,
  output logic               p1_rvalid,
  output logic [31:0]        p0_rdata,
  output logic [31:0]        p1_rdata,
  input  logic [7:0]         sram0_q,
  input  logic [7:0]         sram1_q,
  input  logic [7:0]         sram2_q,
  input  logic [7:0]         sram3_q,
  input  logic [7:0]         sram4_q,
  input  logic [7:0]         sram5_q,
  input  logic [7:0]         sram6_q,
  input  logic [7:0]         sram7_q,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addrout,
  output logic [31:0]        sram_wdata,
  output logic [3:0]         sram_bank0_sel,
  output logic [3:0]         sram_bank1_sel
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic              last_win_q, last_win_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_port_q, rd_port_d;
  logic              rd_bank_q, rd_bank_d;

  port_req_t p0, p1, sel;
  logic      gnt0, gnt1, any_gnt;
  logic      unused_addr;
  logic [31:0] rd_word;

  assign p0 = {p0_req, p0_lock, p0_we, p0_addr, p0_be, p0_wdata};
  assign p1 = {p1_req, p1_lock, p1_we, p1_addr, p1_be, p1_wdata};

  // A saturated owner yields at once to a waiting peer
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      OWN0: begin
        if (hold_cnt_q == HOLD_MAX && p1.req) gnt1 = 1'b1;
        else                                  gnt0 = p0.req;
      end
      OWN1: begin
        if (hold_cnt_q == HOLD_MAX && p0.req) gnt0 = 1'b1;
        else                                  gnt1 = p1.req;
      end
      default: begin
        gnt0 = p0.req;
        gnt1 = p1.req;
        if (p0.req && p1.req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
          gnt1 = 1'b0;
`else
          gnt0 = last_win_q;
          gnt1 = !last_win_q;
`endif
        end
      end
    endcase
  end

  assign any_gnt     = gnt0 | gnt1;
  assign sel         = gnt1 ? p1 : p0;
  assign unused_addr = ^sel.addr[14:13];

  always_comb begin
    state_d    = IDLE;
    hold_cnt_d = '0;
    last_win_d = last_win_q;
    rd_pend_d  = any_gnt & ~sel.we;
    rd_port_d  = gnt1;
    rd_bank_d  = sel.addr[BANK_BIT];
    if (any_gnt) begin
      last_win_d = gnt1;
      if (sel.lock) begin
        state_d = gnt1 ? OWN1 : OWN0;
        if (state_q == state_d)
          hold_cnt_d = (hold_cnt_q == HOLD_MAX) ?
                       HOLD_MAX : hold_cnt_q + 1'b1;
        else
          hold_cnt_d = HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q    <= IDLE;
      last_win_q <= 1'b1;
      hold_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_port_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      hold_cnt_q <= hold_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_port_q  <= rd_port_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  assign p0_gnt       = gnt0;
  assign p1_gnt       = gnt1;
  assign sram_we      = any_gnt & sel.we;
  assign sram_addrout = any_gnt ? sel.addr[SRAM_AW-1:0] : '0;
  assign sram_wdata   = any_gnt ? sel.wdata : '0;

  sram_bank_decode u_dec (
    .bank      (sel.addr[BANK_BIT]),
    .be        (sel.be),
    .en        (any_gnt),
    .bank0_sel (sram_bank0_sel),
    .bank1_sel (sram_bank1_sel)
  );

  assign rd_word = rd_bank_q ?
                   {sram7_q, sram6_q, sram5_q, sram4_q} :
                   {sram3_q, sram2_q, sram1_q, sram0_q};

  assign p0_rvalid = rd_pend_q & ~rd_port_q;
  assign p1_rvalid = rd_pend_q &  rd_port_q;
  assign p0_rdata  = p0_rvalid ? rd_word : '0;
  assign p1_rdata  = p1_rvalid ? rd_word : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: reference arbitration model,
// reference memory, SRAM array model and a decoupled read-return monitor.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int PER  = 10;
  localparam int MAXH = 8;

  typedef struct {
    longint      t;
    logic [31:0] d;
    logic [31:0] m;
  } rd_exp_t;

  logic        hclk   = 1'b0;
  logic        hrst_n = 1'b0;
  port_req_t   d0 = '0;
  port_req_t   d1 = '0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata, sram_wdata;
  logic        sram_we;
  logic [12:0] sram_addrout;
  logic [3:0]  sram_bank0_sel, sram_bank1_sel;
  logic [7:0]  sq [8] = '{default: '0};
  logic [7:0]  smem [8][8] = '{default: '0};
  logic [31:0] ref_mem [2][8] = '{default: '0};
  logic [7:0]  sel8;

  rd_exp_t q0[$];
  rd_exp_t q1[$];
  int n_vec = 0;
  int n_err = 0;
  int m_owner = -1;
  int m_streak = 0;
  int m_pref = 0;

  always #(PER/2) hclk = ~hclk;

  sram_port_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
    .hclk(hclk), .hrst_n(hrst_n),
    .p0_req(d0.req), .p1_req(d1.req),
    .p0_lock(d0.lock), .p1_lock(d1.lock),
    .p0_we(d0.we), .p1_we(d1.we),
    .p0_addr(d0.addr), .p1_addr(d1.addr),
    .p0_be(d0.be), .p1_be(d1.be),
    .p0_wdata(d0.wdata), .p1_wdata(d1.wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .sram0_q(sq[0]), .sram1_q(sq[1]), .sram2_q(sq[2]), .sram3_q(sq[3]),
    .sram4_q(sq[4]), .sram5_q(sq[5]), .sram6_q(sq[6]), .sram7_q(sq[7]),
    .sram_we(sram_we), .sram_addrout(sram_addrout),
    .sram_wdata(sram_wdata),
    .sram_bank0_sel(sram_bank0_sel), .sram_bank1_sel(sram_bank1_sel)
  );

  // SRAM array: 8 words per device, aliased on addr[2:0] like ref_mem
  assign sel8 = {sram_bank1_sel, sram_bank0_sel};
  always @(posedge hclk) begin
    for (int i = 0; i < 8; i++) begin
      if (sel8[i]) begin
        if (sram_we) smem[i][sram_addrout[2:0]] <= sram_wdata[8*(i%4) +: 8];
        else         sq[i] <= smem[i][sram_addrout[2:0]];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event, want none at %0t", nm, $time);
  endtask

  function automatic port_req_t mk(input logic lk, input logic we,
                                   input logic [15:0] a, input logic [3:0] be,
                                   input logic [31:0] wd);
    port_req_t t;
    t = '{req: 1'b1, lock: lk, we: we, addr: a, be: be, wdata: wd};
    return t;
  endfunction

  function automatic port_req_t rnd_txn(input int lock_pct);
    port_req_t t;
    t.req   = 1'b1;
    t.lock  = $urandom_range(99) < lock_pct;
    t.we    = 1'($urandom_range(1));
    t.addr  = 16'($urandom);
    t.be    = ($urandom_range(1) == 1) ? 4'hF : 4'($urandom);
    t.wdata = $urandom;
    return t;
  endfunction

  // Reference arbitration: owner, streak length and tie preference
  task automatic model_step(input port_req_t a, input port_req_t b,
                            output int w);
    logic [1:0] rq;
    port_req_t  t;
    rq = {b.req, a.req};
    w  = -1;
    if (m_owner >= 0) begin
      if (m_streak >= MAXH && rq[1-m_owner] == 1'b1) w = 1 - m_owner;
      else if (rq[m_owner] == 1'b1)                 w = m_owner;
    end else if (rq == 2'b11) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = m_pref;
`endif
    end else if (rq[0]) w = 0;
    else if (rq[1])     w = 1;
    if (w < 0) begin
      m_owner  = -1;
      m_streak = 0;
    end else begin
      t      = (w == 1) ? b : a;
      m_pref = 1 - w;
      if (!t.lock) begin
        m_owner  = -1;
        m_streak = 0;
      end else if (m_owner == w) begin
        m_streak = (m_streak < MAXH) ? m_streak + 1 : MAXH;
      end else begin
        m_owner  = w;
        m_streak = 1;
      end
    end
  endtask

  task automatic run_cycle(input port_req_t a, input port_req_t b,
                           output int w, output int dg);
    port_req_t   t;
    logic [31:0] m;
    logic [53:0] ecmd;
    @(posedge hclk);
    #1;
    d0 = a;
    d1 = b;
    @(negedge hclk);
    dg = p1_gnt ? 1 : (p0_gnt ? 0 : -1);
    model_step(a, b, w);
    chk("gnt", {62'd0, p1_gnt, p0_gnt}, {62'd0, w == 1, w == 0});
    t    = (w == 1) ? b : a;
    ecmd = '0;
    if (w >= 0)
      ecmd = {t.we, t.addr[12:0], t.wdata,
              t.addr[15] ? t.be : 4'h0, t.addr[15] ? 4'h0 : t.be};
    chk("sram_cmd", {10'd0, sram_we, sram_addrout, sram_wdata,
                     sram_bank1_sel, sram_bank0_sel}, {10'd0, ecmd});
    if (w >= 0) begin
      if (t.we) begin
        for (int l = 0; l < 4; l++)
          if (t.be[l])
            ref_mem[t.addr[15]][t.addr[2:0]][8*l +: 8] = t.wdata[8*l +: 8];
      end else begin
        m = {{8{t.be[3]}}, {8{t.be[2]}}, {8{t.be[1]}}, {8{t.be[0]}}};
        if (w == 1) q1.push_back('{t: longint'($time),
                                   d: ref_mem[t.addr[15]][t.addr[2:0]], m: m});
        else        q0.push_back('{t: longint'($time),
                                   d: ref_mem[t.addr[15]][t.addr[2:0]], m: m});
      end
    end
  endtask

  // Called just after a negedge; reset is asynchronous and drops in-flight reads
  task automatic do_reset(input int cycles);
    #2;
    hrst_n = 1'b0;
    d0 = '0;
    d1 = '0;
    q0.delete();
    q1.delete();
    m_owner  = -1;
    m_streak = 0;
    m_pref   = 0;
    repeat (cycles) begin
      @(negedge hclk);
      chk("rst_ctl", {33'd0, p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, sram_we,
                      sram_bank1_sel, sram_bank0_sel, sram_addrout}, 64'd0);
      chk("rst_data", {sram_wdata, p0_rdata | p1_rdata}, 64'd0);
    end
    #2;
    hrst_n = 1'b1;
  endtask

  task automatic mon(input int p, input logic v, input logic [31:0] rd);
    rd_exp_t e;
    logic    have;
    have = (p == 1) ? (q1.size() > 0) : (q0.size() > 0);
    if (v) begin
      if (!have) fail(p == 1 ? "p1_rvalid_unexpected" : "p0_rvalid_unexpected");
      else begin
        e = (p == 1) ? q1.pop_front() : q0.pop_front();
        chk("rd_latency", 64'(longint'($time) - e.t), 64'(PER));
        chk(p == 1 ? "p1_rdata" : "p0_rdata", {32'd0, rd & e.m},
            {32'd0, e.d & e.m});
      end
    end else begin
      chk("rdata_idle", {32'd0, rd}, 64'd0);
      if (have) begin
        e = (p == 1) ? q1[0] : q0[0];
        if (longint'($time) - e.t > PER) begin
          fail(p == 1 ? "p1_rvalid_missing" : "p0_rvalid_missing");
          if (p == 1) void'(q1.pop_front());
          else        void'(q0.pop_front());
        end
      end
    end
  endtask

  always @(negedge hclk) begin
    if (hrst_n) begin
      mon(0, p0_rvalid, p0_rdata);
      mon(1, p1_rvalid, p1_rdata);
    end
  end

  initial begin
    port_req_t c0, c1, z;
    int w, dg, first, r0, r1, l0, l1;
    z = '0;
    do_reset(3);

    repeat (2) run_cycle(z, z, w, dg);

    run_cycle(mk(1'b0, 1'b1, 16'h8004, 4'b0011, 32'hA5A5_1234), z, w, dg);
    chk("t2_cmd", {34'd0, sram_we, sram_addrout, sram_bank1_sel,
                   sram_bank0_sel}, {34'd0, 1'b1, 13'h0004, 4'b0011, 4'b0000});

    c0 = mk(1'b0, 1'b1, 16'h0000, 4'hF, 32'h4433_2211);
    c1 = mk(1'b0, 1'b0, 16'h0000, 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      run_cycle(c0, c1, w, dg);
      if (w == 0) c0 = mk(1'b0, 1'b0, 16'h0001, 4'hF, 32'h0);
    end

    @(negedge hclk);
    do_reset(2);
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      run_cycle(mk(1'b1, 1'b1, 16'(k), 4'hF, $urandom),
                mk(1'b0, 1'b1, 16'h8000 | 16'(k), 4'hF, $urandom), w, dg);
      if (dg == 1 && first < 0) first = k;
    end
    chk("t4_p1_first_gnt", 64'(first), 64'd9);

    @(negedge hclk);
    do_reset(1);
    run_cycle(z, mk(1'b1, 1'b0, 16'h0002, 4'hF, 32'h0), w, dg);
    run_cycle(z, mk(1'b1, 1'b0, 16'h8003, 4'hF, 32'h0), w, dg);
    do_reset(2);
    run_cycle(mk(1'b0, 1'b0, 16'h0005, 4'hF, 32'h0),
              mk(1'b0, 1'b0, 16'h0006, 4'hF, 32'h0), w, dg);
    chk("t5_first_tie", 64'(dg), 64'd0);

    c0 = z;
    c1 = z;
    for (int n = 0; n < 1500; n++) begin
      unique case (n / 300)
        0:       begin r0 = 100; l0 = 95; r1 = 70;  l1 = 10; end
        1:       begin r0 = 70;  l0 = 10; r1 = 100; l1 = 95; end
        2:       begin r0 = 60;  l0 = 40; r1 = 60;  l1 = 40; end
        3:       begin r0 = 100; l0 = 0;  r1 = 100; l1 = 0;  end
        default: begin r0 = 50;  l0 = 70; r1 = 50;  l1 = 70; end
      endcase
      if (!c0.req && $urandom_range(99) < r0) c0 = rnd_txn(l0);
      if (!c1.req && $urandom_range(99) < r1) c1 = rnd_txn(l1);
      run_cycle(c0, c1, w, dg);
      if (w == 0) c0 = z;
      if (w == 1) c1 = z;
      if (n == 750) begin
        do_reset(2);
        c0 = z;
        c1 = z;
      end
    end

    repeat (3) run_cycle(z, z, w, dg);
    chk("rd_drain", 64'(q0.size() + q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
